rom_load_sequencer: RTL
=======================

Name: rom_load_sequencer

Overview:
Sequences the HPS ROM download stream into the arcade core's ROM regions and owns the core reset.
- Decodes the linear download address into CPU ROM, graphics ROM and colour PROM regions.
- Re-times each write into a single-cycle core write strobe.
- Counts and checksums accepted bytes.
- Holds the core in reset until a complete image has loaded and a settle delay has expired.
- Sits between hps_io download outputs and the core's dn_addr/dn_data/dn_wr inputs, replacing the ad-hoc reset OR term.

Parameters:
CPU_SIZE, 16384, bytes in CPU ROM region (region 0, base 0)
GFX_SIZE, 4096, bytes in graphics ROM region (region 1, base CPU_SIZE)
PROM_SIZE, 32, bytes in colour PROM region (region 2, base CPU_SIZE+GFX_SIZE)
SETTLE_CYCLES, 16, clk_sys cycles core_reset stays high after a good load (>=1)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download in progress (level)
ioctl_wr  in  1  byte write strobe, one cycle per byte
ioctl_addr  in  25  linear byte address of current write
ioctl_dout  in  8  download data byte
soft_reset  in  1  user reset request (OSD/button), synchronous level
dn_addr  out  16  byte address to core (ioctl_addr[15:0])
dn_data  out  8  byte to core
dn_wr  out  1  single-cycle core write strobe
dn_region  out  3  one-hot region of the current dn_wr (bit0 CPU, bit1 GFX, bit2 PROM)
core_reset  out  1  reset to core
load_done  out  1  last load complete and size-correct
load_error  out  1  last load wrong size or had out-of-range writes
byte_count  out  16  accepted bytes in current/last load
checksum  out  16  mod-2^16 sum of accepted bytes

Behaviour:
- TOTAL = CPU_SIZE+GFX_SIZE+PROM_SIZE. TOTAL must be <= 65535, so 16-bit counters never wrap on a correct image.
- States: IDLE, LOAD, SETTLE, RUN.
- Reset (async) values:
  - state=IDLE, core_reset=1.
  - dn_wr=0, dn_addr=0, dn_data=0, dn_region=0.
  - load_done=0, load_error=0, byte_count=0, checksum=0.
- IDLE: core_reset=1. Rising edge of ioctl_download -> LOAD.
- Entering LOAD:
  - Same cycle the rising edge is detected: byte_count=0, checksum=0, load_done=0, load_error=0, core_reset=1.
  - A rising edge in any state (including SETTLE/RUN) restarts LOAD.
- LOAD write path: for each cycle with ioctl_wr=1, in the next cycle:
  - dn_wr=1 for exactly one cycle.
  - dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout registered from the strobe cycle. They hold until the next accepted write.
  - dn_region is set per the decode below.
  - byte_count += 1; checksum += zero-extended byte.
  - Latency from ioctl_wr to dn_wr is 1 cycle. Back-to-back ioctl_wr gives back-to-back dn_wr.
- Region decode:
  - addr < CPU_SIZE -> 3'b001.
  - addr < CPU_SIZE+GFX_SIZE -> 3'b010.
  - addr < TOTAL -> 3'b100.
  - addr >= TOTAL, or ioctl_addr[24:16] != 0 -> write dropped: no dn_wr, no count, no checksum, sticky overflow flag set.
- ioctl_wr outside LOAD is ignored.
- Falling edge of ioctl_download in LOAD:
  - byte_count==TOTAL and no overflow -> SETTLE; load_done=1.
  - Otherwise -> IDLE; load_error=1, load_done=0. core_reset stays 1 until the next download.
- A falling edge coinciding with a final ioctl_wr: that byte is counted before the size check. The check is evaluated one cycle after the edge, using the pipeline result.
- SETTLE: core_reset=1. Counter runs 0..SETTLE_CYCLES-1, then -> RUN.
- RUN: core_reset = soft_reset. soft_reset=1 in RUN -> SETTLE with the counter cleared. The core is never released without a good image.
- soft_reset in IDLE/LOAD/SETTLE has no additional effect, except that SETTLE restarts its counter.
- byte_count, checksum, load_done and load_error hold their values after LOAD until the next rising edge of ioctl_download.

Test Plan:
- Good load: after reset, download TOTAL=20512 bytes with data = addr[7:0].
  - dn_wr count = 20512, each 1 cycle after its ioctl_wr.
  - dn_region 001 for addr 0..16383, 010 for 16384..20479, 100 for 20480..20511.
  - byte_count=20512, checksum = expected mod-2^16 sum.
  - load_done=1; core_reset falls exactly 16 cycles after SETTLE entry.
- Short load: 20511 bytes -> load_error=1, load_done=0, state IDLE, core_reset stays 1 indefinitely.
- Out-of-range write: addr 20512 with 0xAA inserted in a full load -> no dn_wr for it, checksum excludes 0xAA, load_error=1.
- Back-to-back strobes at addr 0,1,2 with data 0x11,0x22,0x33 -> dn_wr high 3 consecutive cycles, delayed 1 cycle, matching addr/data.
- Soft reset in RUN: pulse soft_reset 1 cycle -> core_reset=1 for that cycle plus 16 SETTLE cycles, then 0; load_done stays 1.
- Async reset mid-LOAD after 100 bytes -> all outputs to reset values immediately; new download then completes normally with byte_count=TOTAL.

Source files
------------

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Steers the HPS ROM download stream into the core's ROM regions and owns
//   the core reset. Each accepted ioctl write is re-issued one cycle later as
//   a single-cycle dn_wr with its decoded one-hot region. Accepted bytes are
//   counted and summed. The core is held in reset until a complete,
//   size-correct image has loaded and a settle delay has expired.
//
// Ports:
//   clk_sys, reset          clock and asynchronous active-high reset
//   ioctl_download          download in progress (level)
//   ioctl_wr/addr/dout      byte write strobe, linear address, data
//   soft_reset              user reset request (synchronous level)
//   dn_addr/data/wr/region  re-timed write to the core
//   core_reset              reset to the core
//   load_done/load_error    result of the last load
//   byte_count/checksum     accepted bytes and their mod-2^16 sum

module rom_load_sequencer #(
  parameter int CPU_SIZE      = 16384,
  parameter int GFX_SIZE      = 4096,
  parameter int PROM_SIZE     = 32,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        soft_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [2:0]  dn_region,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] byte_count,
  output logic [15:0] checksum
);

  localparam int TOTAL = CPU_SIZE + GFX_SIZE + PROM_SIZE;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [24:0]   GFX_BASE    = 25'(CPU_SIZE);
  localparam logic [24:0]   PROM_BASE   = 25'(CPU_SIZE + GFX_SIZE);
  localparam logic [24:0]   END_ADDR    = 25'(TOTAL);
  localparam logic [15:0]   TOTAL16     = 16'(TOTAL);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic          dl_prev_q, dl_prev_d;
  logic          check_pend_q, check_pend_d;
  logic          overflow_q, overflow_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic          core_reset_q, core_reset_d;
  logic          dn_wr_q, dn_wr_d;
  logic [15:0]   dn_addr_q, dn_addr_d;
  logic [7:0]    dn_data_q, dn_data_d;
  logic [2:0]    dn_region_q, dn_region_d;
  logic          load_done_q, load_done_d;
  logic          load_error_q, load_error_d;
  logic [15:0]   byte_count_q, byte_count_d;
  logic [15:0]   checksum_q, checksum_d;

  logic       dl_rise, dl_fall;
  logic [2:0] wr_region;

  assign dl_rise = ioctl_download & ~dl_prev_q;
  assign dl_fall = ~ioctl_download & dl_prev_q;

  // Full 25-bit compare: any set bit in [24:16] lands above END_ADDR and
  // decodes to "no region", which marks the write as dropped.
  always_comb begin
    if (ioctl_addr < GFX_BASE)       wr_region = 3'b001;
    else if (ioctl_addr < PROM_BASE) wr_region = 3'b010;
    else if (ioctl_addr < END_ADDR)  wr_region = 3'b100;
    else                             wr_region = 3'b000;
  end

  always_comb begin
    state_d      = state_q;
    dl_prev_d    = ioctl_download;
    check_pend_d = check_pend_q;
    overflow_d   = overflow_q;
    settle_cnt_d = settle_cnt_q;
    core_reset_d = core_reset_q;
    dn_wr_d      = 1'b0;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_region_d  = dn_region_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;

    if (dl_rise) begin
      // A new download always wins, whatever state we are in.
      state_d      = S_LOAD;
      check_pend_d = 1'b0;
      overflow_d   = 1'b0;
      core_reset_d = 1'b1;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
      byte_count_d = 16'd0;
      checksum_d   = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: core_reset_d = 1'b1;
        S_LOAD: begin
          core_reset_d = 1'b1;
          if (check_pend_q) begin
            // Size check runs one cycle after the falling edge so a byte
            // written in the edge cycle is already counted.
            check_pend_d = 1'b0;
            if (byte_count_q == TOTAL16 && !overflow_q) begin
              state_d      = S_SETTLE;
              settle_cnt_d = '0;
              load_done_d  = 1'b1;
            end else begin
              state_d      = S_IDLE;
              load_done_d  = 1'b0;
              load_error_d = 1'b1;
            end
          end else begin
            if (ioctl_wr) begin
              if (wr_region != 3'b000) begin
                dn_wr_d      = 1'b1;
                dn_addr_d    = ioctl_addr[15:0];
                dn_data_d    = ioctl_dout;
                dn_region_d  = wr_region;
                byte_count_d = byte_count_q + 16'd1;
                checksum_d   = checksum_q + {8'h00, ioctl_dout};
              end else begin
                overflow_d = 1'b1;
              end
            end
            if (dl_fall) check_pend_d = 1'b1;
          end
        end
        S_SETTLE: begin
          core_reset_d = 1'b1;
          if (soft_reset) begin
            settle_cnt_d = '0;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = S_RUN;
            core_reset_d = 1'b0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          core_reset_d = 1'b0;
          if (soft_reset) begin
            state_d      = S_SETTLE;
            settle_cnt_d = '0;
            core_reset_d = 1'b1;
          end
        end
        default: begin
          state_d      = S_IDLE;
          core_reset_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dl_prev_q    <= 1'b0;
      check_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      settle_cnt_q <= '0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= 16'd0;
      dn_data_q    <= 8'd0;
      dn_region_q  <= 3'b000;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      byte_count_q <= 16'd0;
      checksum_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= dl_prev_d;
      check_pend_q <= check_pend_d;
      overflow_q   <= overflow_d;
      settle_cnt_q <= settle_cnt_d;
      core_reset_q <= core_reset_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_region_q  <= dn_region_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
    end
  end

  // In RUN the core reset follows soft_reset directly, so a request is seen
  // by the core in the same cycle; the registered term then covers SETTLE.
  assign core_reset = core_reset_q | ((state_q == S_RUN) & soft_reset);
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_region  = dn_region_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;

endmodule
